// File: rtl/mc_controller_if.sv
// Handshake and datapath-control bundle between the multicycle controller
// and its datapath/memory side.
interface mc_controller_if;
    logic [5:0] opcode;
    logic       mem_ready;

    logic       mem_req;
    logic       iord;
    logic       memwrite;
    logic       irwrite;
    logic       pcwrite;
    logic       branch;
    logic       regwrite;
    logic       regdst;
    logic       memtoreg;
    logic       alusrca;
    logic [1:0] alusrcb;
    logic [1:0] pcsrc;
    logic [1:0] aluop;
    logic       illegal_op;
    logic       instr_done;

    modport master (
        input  opcode, mem_ready,
        output mem_req, iord, memwrite, irwrite, pcwrite, branch, regwrite,
               regdst, memtoreg, alusrca, alusrcb, pcsrc, aluop,
               illegal_op, instr_done
    );

    modport slave (
        output opcode, mem_ready,
        input  mem_req, iord, memwrite, irwrite, pcwrite, branch, regwrite,
               regdst, memtoreg, alusrca, alusrcb, pcsrc, aluop,
               illegal_op, instr_done
    );
endinterface

// File: rtl/mc_controller.sv
// Multicycle MIPS-subset main controller: Moore FSM sequencing the datapath
// through fetch/decode/execute plus a retired-instruction counter.
module mc_controller #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    mc_controller_if.master  bus,
    output logic [3:0]       state_o,
    output logic [CNT_W-1:0] retired
);

    typedef enum logic [3:0] {
        FETCH   = 4'd0,
        DECODE  = 4'd1,
        MEMADR  = 4'd2,
        MEMRD   = 4'd3,
        MEMWB   = 4'd4,
        MEMWR   = 4'd5,
        RTYPEEX = 4'd6,
        RTYPEWB = 4'd7,
        BEQEX   = 4'd8,
        ADDIEX  = 4'd9,
        ADDIWB  = 4'd10,
        JEX     = 4'd11
    } state_t;

    localparam logic [5:0] OP_LW   = 6'b100011;
    localparam logic [5:0] OP_SW   = 6'b101011;
    localparam logic [5:0] OP_RTYP = 6'b000000;
    localparam logic [5:0] OP_BEQ  = 6'b000100;
    localparam logic [5:0] OP_ADDI = 6'b001000;
    localparam logic [5:0] OP_J    = 6'b000010;

    state_t state;

    assign state_o = state;

    // NOTE: all state uses non-blocking assignments so every register samples
    // pre-edge values; reset is synchronous because the surrounding design
    // samples rst_n on the clock.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state   <= FETCH;
            retired <= '0;
        end else begin
            if (bus.instr_done)
                retired <= retired + 1'b1;
            case (state)
                FETCH:   if (bus.mem_ready) state <= DECODE;
                DECODE: begin
                    case (bus.opcode)
                        OP_LW, OP_SW: state <= MEMADR;
                        OP_RTYP:      state <= RTYPEEX;
                        OP_BEQ:       state <= BEQEX;
                        OP_ADDI:      state <= ADDIEX;
                        OP_J:         state <= JEX;
                        default:      state <= FETCH;
                    endcase
                end
                MEMADR:  state <= (bus.opcode == OP_SW) ? MEMWR : MEMRD;
                MEMRD:   if (bus.mem_ready) state <= MEMWB;
                MEMWR:   if (bus.mem_ready) state <= FETCH;
                RTYPEEX: state <= RTYPEWB;
                ADDIEX:  state <= ADDIWB;
                default: state <= FETCH;
            endcase
        end
    end

    // NOTE: every output gets a default before the case so no latch is
    // inferred for outputs a state leaves unmentioned.
    always_comb begin
        bus.mem_req    = 1'b0;
        bus.iord       = 1'b0;
        bus.memwrite   = 1'b0;
        bus.irwrite    = 1'b0;
        bus.pcwrite    = 1'b0;
        bus.branch     = 1'b0;
        bus.regwrite   = 1'b0;
        bus.regdst     = 1'b0;
        bus.memtoreg   = 1'b0;
        bus.alusrca    = 1'b0;
        bus.alusrcb    = 2'b00;
        bus.pcsrc      = 2'b00;
        bus.aluop      = 2'b00;
        bus.illegal_op = 1'b0;
        bus.instr_done = 1'b0;
        case (state)
            FETCH: begin
                bus.mem_req = 1'b1;
                bus.alusrcb = 2'b01;
                bus.irwrite = bus.mem_ready;
                bus.pcwrite = bus.mem_ready;
            end
            DECODE: begin
                bus.alusrcb = 2'b11;
                case (bus.opcode)
                    OP_LW, OP_SW, OP_RTYP, OP_BEQ, OP_ADDI, OP_J: ;
                    default: bus.illegal_op = 1'b1;
                endcase
            end
            MEMADR, ADDIEX: begin
                bus.alusrca = 1'b1;
                bus.alusrcb = 2'b10;
            end
            MEMRD: begin
                bus.mem_req = 1'b1;
                bus.iord    = 1'b1;
            end
            MEMWR: begin
                // Write strobe is held for the whole wait; retirement only on completion.
                bus.mem_req    = 1'b1;
                bus.iord       = 1'b1;
                bus.memwrite   = 1'b1;
                bus.instr_done = bus.mem_ready;
            end
            MEMWB: begin
                bus.regwrite   = 1'b1;
                bus.memtoreg   = 1'b1;
                bus.instr_done = 1'b1;
            end
            RTYPEEX: begin
                bus.alusrca = 1'b1;
                bus.aluop   = 2'b10;
            end
            RTYPEWB: begin
                bus.regwrite   = 1'b1;
                bus.regdst     = 1'b1;
                bus.instr_done = 1'b1;
            end
            ADDIWB: begin
                bus.regwrite   = 1'b1;
                bus.instr_done = 1'b1;
            end
            BEQEX: begin
                bus.alusrca    = 1'b1;
                bus.aluop      = 2'b01;
                bus.pcsrc      = 2'b01;
                bus.branch     = 1'b1;
                bus.instr_done = 1'b1;
            end
            JEX: begin
                bus.pcsrc      = 2'b10;
                bus.pcwrite    = 1'b1;
                bus.instr_done = 1'b1;
            end
            default: ;
        endcase
    end

endmodule

// File: doc/mc_controller.md
MC_CONTROLLER -- requirements
Module: mc_controller

Interface
REQ-001 Parameter: CNT_W, 16, width of retired-instruction counter.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst_n  input  1  reset, synchronous and active-low.
REQ-004 opcode  input  6  instr[31:26] from instruction register; stable from DECODE until return to FETCH.
REQ-005 mem_ready  input  1  memory handshake; 1 = access completes this cycle.
REQ-006 mem_req  output  1  memory access request.
REQ-007 iord, memwrite, irwrite, pcwrite, branch, regwrite, regdst, memtoreg, alusrca  output  1 each  datapath strobes/selects.
REQ-008 alusrcb  output  2  ALU B select: 00 reg, 01 const 4, 10 signext imm, 11 imm<<2.
REQ-009 pcsrc  output  2  PC source: 00 ALU result, 01 ALUOut, 10 jump target.
REQ-010 aluop  output  2  to ALU decoder: 00 add, 01 sub, 10 use funct; 11 never driven.
REQ-011 illegal_op  output  1  one-cycle pulse on unsupported opcode.
REQ-012 instr_done  output  1  one-cycle pulse on final cycle of a retired instruction.
REQ-013 state_o  output  4  current state encoding, debug.
REQ-014 retired  output  CNT_W  count of retired instructions.

Function
REQ-015 Moore FSM, states (encoding 0-11): FETCH, DECODE, MEMADR, MEMRD, MEMWB, MEMWR, RTYPEEX, RTYPEWB, BEQEX, ADDIEX, ADDIWB, JEX.
REQ-016 Opcodes: lw 100011, sw 101011, R-type 000000, beq 000100, addi 001000, j 000010; all others illegal.
REQ-017 FETCH: hold until mem_ready=1, then DECODE.
REQ-018 DECODE: lw/sw->MEMADR, R-type->RTYPEEX, beq->BEQEX, addi->ADDIEX, j->JEX, illegal->FETCH with illegal_op=1 this cycle.
REQ-019 MEMADR: lw->MEMRD, sw->MEMWR.
REQ-020 MEMRD: hold until mem_ready=1, then MEMWB; MEMWR: hold until mem_ready=1, then FETCH.
REQ-021 RTYPEEX->RTYPEWB, ADDIEX->ADDIWB, unconditional; MEMWB, RTYPEWB, ADDIWB, BEQEX, JEX->FETCH unconditional.
REQ-022 Outputs per state; unlisted outputs 0:
- FETCH: mem_req=1, alusrcb=01, aluop=00, irwrite=pcwrite=mem_ready.
- DECODE: alusrcb=11, aluop=00.
- MEMADR, ADDIEX: alusrca=1, alusrcb=10, aluop=00.
- MEMRD: mem_req=1, iord=1.
- MEMWR: mem_req=1, iord=1, memwrite=1 (held every wait cycle).
- MEMWB: regwrite=1, memtoreg=1, regdst=0.
- RTYPEEX: alusrca=1, alusrcb=00, aluop=10.
- RTYPEWB: regwrite=1, regdst=1.
- ADDIWB: regwrite=1, regdst=0, memtoreg=0.
- BEQEX: alusrca=1, alusrcb=00, aluop=01, pcsrc=01, branch=1.
- JEX: pcsrc=10, pcwrite=1.
REQ-023 instr_done=1 exactly in the last state cycle of each retired instruction: MEMWB, MEMWR with mem_ready=1, RTYPEWB, ADDIWB, BEQEX, JEX; never on illegal opcode.
REQ-024 retired increments by 1 on the clock edge ending each instr_done cycle; wraps from all-ones to 0.
REQ-025 Latency with mem_ready=1 throughout: lw 5, sw 4, R-type 4, addi 4, beq 3, j 3 cycles; each memory wait cycle adds 1.
REQ-026 Strobes per cycle: regwrite, memwrite, irwrite each asserted in at most one state per instruction, and never simultaneously with another of the three.

Reset
REQ-027 rst_n=0 at a rising edge: next state FETCH, retired=0, regardless of current state or pending memory wait.
REQ-028 After reset, outputs are the FETCH decode; with mem_ready=0, all strobes 0, mem_req=1.
REQ-029 Reset mid-instruction abandons it: no instr_done, no counter increment.

Verification
REQ-030 Reset, mem_ready=1, opcode lw -> states FETCH,DECODE,MEMADR,MEMRD,MEMWB,FETCH; regwrite=1 only in MEMWB; retired=1.
REQ-031 sw with mem_ready=0 for 3 cycles in MEMWR -> memwrite=1 for 4 cycles; single instr_done; retired +1.
REQ-032 R-type -> aluop=10 in RTYPEEX, regdst=1 & regwrite=1 in RTYPEWB; beq -> branch=1, pcsrc=01, aluop=01 in BEQEX.
REQ-033 opcode 111111 -> illegal_op=1 in DECODE, next FETCH, retired unchanged, no instr_done.
REQ-034 rst_n=0 during MEMRD wait -> FETCH next cycle, retired=0; 2^CNT_W retired j instructions -> retired wraps to 0.
